// File: rtl/disp_scan.sv
// Time-multiplexed seven-segment scan driver for five digits.
// Frame-synchronous shadow capture keeps a frame tear-free.
module disp_scan #(
  parameter int DIV  = 1000,
  parameter int DEAD = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [39:0] seg_in,
  input  logic [4:0]  blank,
  input  logic        en,
  output logic [7:0]  seg_out,
  output logic [4:0]  dig_sel,
  output logic        frame_tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [2:0]    idx;
  logic [2:0]    idx_nx;
  logic [39:0]   seg_sh;
  logic [39:0]   seg_sh_nx;
  logic [4:0]    blank_sh;
  logic [4:0]    blank_sh_nx;
  logic          load_pend;
  logic          tick;
  logic          load;
  logic [7:0]    byte_nx;
  logic          blank_bit;
  logic [4:0]    sel_oh;
  logic          dig_on;
  logic [4:0]    dig_nx;

  always_comb begin
    tick   = (cnt == CW'(DIV - 1));
    cnt_nx = tick ? '0 : cnt + 1'b1;
    idx_nx = idx;
    if (tick) begin
      idx_nx = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
    end
    load        = tick && ((idx_nx == 3'd0) || load_pend);
    seg_sh_nx   = load ? seg_in : seg_sh;
    blank_sh_nx = load ? blank : blank_sh;
  end

  // Select the byte, blank bit and enable for the upcoming digit.
  always_comb begin
    byte_nx   = 8'h00;
    blank_bit = 1'b1;
    sel_oh    = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      if (idx_nx == 3'(i)) begin
        byte_nx   = seg_sh_nx[8*i +: 8];
        blank_bit = blank_sh_nx[i];
        sel_oh[i] = 1'b1;
      end
    end
    dig_on = en && (cnt_nx >= CW'(DEAD)) && !blank_bit;
    dig_nx = dig_on ? ~sel_oh : 5'b11111;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= 3'd0;
      seg_sh     <= 40'h0;
      blank_sh   <= 5'b11111;
      load_pend  <= 1'b1;
      seg_out    <= 8'h00;
      dig_sel    <= 5'b11111;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      seg_sh     <= seg_sh_nx;
      blank_sh   <= blank_sh_nx;
      if (load) begin
        load_pend <= 1'b0;
      end
      seg_out    <= byte_nx;
      dig_sel    <= dig_nx;
      frame_tick <= tick && (idx_nx == 3'd0);
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// Randomized bench for disp_scan against a time-based
// reference model (DIV=4, DEAD=1).
module tb_disp_scan;

  localparam int DIV  = 4;
  localparam int DEAD = 1;

  logic        clk;
  logic        rst_n;
  logic [39:0] seg_in;
  logic [4:0]  blank;
  logic        en;
  logic [7:0]  seg_out;
  logic [4:0]  dig_sel;
  logic        frame_tick;

  int n_cmp;
  int n_bad;

  int          t;
  int          last_ft;
  logic [39:0] m_seg;
  logic [4:0]  m_blank;

  disp_scan #(.DIV(DIV), .DEAD(DEAD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_in(seg_in),
    .blank(blank),
    .en(en),
    .seg_out(seg_out),
    .dig_sel(dig_sel),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%0h exp=%0h",
               tag, t, got, exp);
    end
  endtask

  function automatic int cur_idx();
    return (t / DIV) % 5;
  endfunction

  // One clock: t counts edges since reset release.
  // Slot s = t/DIV; shadow loads on slot 1 and every
  // slot that is a multiple of five.
  task automatic step();
    int s;
    int ix;
    logic [7:0] e_seg;
    logic [4:0] e_dig;
    logic       e_ft;
    @(posedge clk);
    t++;
    s = t / DIV;
    if ((t % DIV == 0) && (s == 1 || s % 5 == 0)) begin
      m_seg   = seg_in;
      m_blank = blank;
    end
    ix    = s % 5;
    e_seg = m_seg[8*ix +: 8];
    e_ft  = (t % DIV == 0) && (s % 5 == 0);
    e_dig = 5'b11111;
    if (en && (t % DIV) >= DEAD && !m_blank[ix])
      e_dig[ix] = 1'b0;
    #1;
    chk("seg_out", 64'(seg_out), 64'(e_seg));
    chk("dig_sel", 64'(dig_sel), 64'(e_dig));
    chk("frame_tick", 64'(frame_tick), 64'(e_ft));
    if (frame_tick) begin
      if (last_ft > 0)
        chk("ft_period", 64'(t - last_ft), 64'(5 * DIV));
      last_ft = t;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_seg", 64'(seg_out), 64'h00);
    chk("rst_dig", 64'(dig_sel), 64'h1f);
    chk("rst_ft", 64'(frame_tick), 64'h0);
    @(negedge clk);
    t       = 0;
    last_ft = 0;
    m_seg   = 40'h0;
    m_blank = 5'b11111;
    rst_n   = 1'b1;
  endtask

  task automatic run_rand(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if ($urandom_range(7) == 0)
        seg_in = {8'($urandom), $urandom};
      if ($urandom_range(15) == 0)
        blank = 5'($urandom);
      if ($urandom_range(9) == 0)
        en = ~en;
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    t       = 0;
    last_ft = 0;
    m_seg   = 40'h0;
    m_blank = 5'b11111;
    rst_n   = 1'b0;
    seg_in  = 40'h0102030405;
    blank   = 5'b00000;
    en      = 1'b1;
    #22;
    do_reset();

    // post-reset load
    repeat (4) step();
    chk("pr_seg_c4", 64'(seg_out), 64'h04);
    chk("pr_dig_c4", 64'(dig_sel), 64'h1f);
    step();
    chk("pr_dig_c5", 64'(dig_sel), 64'h1d);

    // scan order: new data shows from next frame
    seg_in = 40'h4433221100;
    repeat (60) step();

    // tear-free: change while idx == 2
    while (cur_idx() != 2) step();
    seg_in = 40'hAAAAAAAAAA;
    while (cur_idx() != 3) step();
    chk("tear_d3", 64'(seg_out), 64'h33);
    while (cur_idx() != 4) step();
    chk("tear_d4", 64'(seg_out), 64'h44);
    while (cur_idx() != 0) step();
    chk("tear_d0", 64'(seg_out), 64'hAA);

    // blanking
    blank = 5'b10001;
    repeat (45) step();

    // enable off 30 cycles, back on mid-slot
    blank = 5'b00000;
    repeat (25) step();
    en = 1'b0;
    repeat (30) step();
    while ((t % DIV) != 1) step();
    en = 1'b1;
    step();
    chk("en_on", 64'(dig_sel != 5'b11111), 64'h1);

    run_rand(500);

    // async reset mid-scan
    @(negedge clk);
    #2;
    do_reset();
    seg_in = {8'($urandom), $urandom};
    run_rand(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
